// File: rtl/exibe_sequencia_if.sv
// exibe_sequencia_if: control, ROM and display signals of the sequence presenter
interface exibe_sequencia_if;
   logic       iniciar;
   logic       parar;
   logic [3:0] limite;
   logic [3:0] dado;
   logic [3:0] endereco;
   logic [3:0] leds;
   logic       exibindo;
   logic       pronto;
   logic [2:0] db_estado;
   modport master (output iniciar, parar, limite, dado,
                   input endereco, leds, exibindo, pronto, db_estado);
   modport slave (input iniciar, parar, limite, dado,
                  output endereco, leds, exibindo, pronto, db_estado);
endinterface

// File: rtl/exibe_sequencia.sv
// exibe_sequencia: shows ROM words 0..limite on the LEDs with fixed on-time and off-gap
module exibe_sequencia #(
   parameter int T_ACESO   = 1000,
   parameter int T_APAGADO = 250
) (
   input logic clock,
   input logic reset,
   exibe_sequencia_if.slave bus
);
   localparam int TMAX = T_ACESO > T_APAGADO ? T_ACESO : T_APAGADO;
   localparam int TW   = TMAX > 1 ? $clog2(TMAX) : 1;
   typedef enum logic [2:0] {
      OCIOSO   = 3'd0,
      ENDERECA = 3'd1,
      CARREGA  = 3'd2,
      ACESO    = 3'd3,
      APAGADO  = 3'd4,
      AVANCA   = 3'd5,
      FIM      = 3'd6
   } estado_t;
   estado_t       estado, prox;
   logic [3:0]    endereco, endereco_n, limite_r, limite_n, led_r, led_n;
   logic [TW-1:0] timer, timer_n;
   // state, address, round limit, LED word and timer registers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         estado   <= OCIOSO;
         endereco <= 4'd0;
         limite_r <= 4'd0;
         led_r    <= 4'd0;
         timer    <= '0;
      end else begin
         estado   <= prox;
         endereco <= endereco_n;
         limite_r <= limite_n;
         led_r    <= led_n;
         timer    <= timer_n;
      end
   end
   // sequencing: address, fetch, show, gap, advance; parar overrides everything
   always_comb begin
      prox       = estado;
      endereco_n = endereco;
      limite_n   = limite_r;
      led_n      = led_r;
      timer_n    = timer;
      case (estado)
         OCIOSO: begin
            endereco_n = 4'd0;
            if (bus.iniciar) begin
               limite_n = bus.limite;
               prox     = ENDERECA;
            end
         end
         ENDERECA: prox = CARREGA;
         CARREGA: begin
            led_n   = bus.dado;
            timer_n = '0;
            prox    = ACESO;
         end
         ACESO: begin
            timer_n = timer == TW'(T_ACESO - 1) ? '0 : timer + 1'b1;
            prox    = timer == TW'(T_ACESO - 1) ? APAGADO : ACESO;
         end
         APAGADO: begin
            timer_n = timer == TW'(T_APAGADO - 1) ? '0 : timer + 1'b1;
            prox    = timer == TW'(T_APAGADO - 1) ? AVANCA : APAGADO;
         end
         AVANCA: begin
            endereco_n = endereco == limite_r ? endereco : endereco + 4'd1;
            prox       = endereco == limite_r ? FIM : ENDERECA;
         end
         FIM: begin
            endereco_n = 4'd0;
            prox       = OCIOSO;
         end
         default: prox = OCIOSO;
      endcase
      if (bus.parar) begin
         prox       = OCIOSO;
         endereco_n = 4'd0;
      end
   end
   assign bus.endereco  = endereco;
   assign bus.leds      = estado == ACESO ? led_r : 4'd0;
   assign bus.exibindo  = estado != OCIOSO && estado != FIM;
   assign bus.pronto    = estado == FIM && !bus.parar;
   assign bus.db_estado = estado;
endmodule

// File: tb/tb_exibe_sequencia.sv
// tb_exibe_sequencia: scoreboard bench for the sequence presenter
module tb_exibe_sequencia;
   localparam int TA  = 4;
   localparam int TP  = 2;
   localparam int PER = TA + TP + 3;
   typedef struct {
      logic [3:0] leds;
      logic       pronto;
      logic       exib;
      logic [2:0] est;
      logic [3:0] ender;
      bit         ender_ok;
   } exp_t;
   logic clock = 1'b0;
   logic reset = 1'b0;
   exibe_sequencia_if bus();
   exibe_sequencia #(.T_ACESO(TA), .T_APAGADO(TP)) dut (.clock(clock), .reset(reset), .bus(bus));
   logic [3:0] rom [16] = '{4'd1, 4'd2, 4'd4, 4'd8, 4'd3, 4'd6, 4'd12, 4'd9,
                            4'd5, 4'd10, 4'd7, 4'd14, 4'd15, 4'd11, 4'd13, 4'd0};
   exp_t q[$];
   exp_t e;
   int checks = 0;
   int passed = 0;
   int sb_cyc = 0;
   always #5 clock = ~clock;
   // synchronous ROM stub: data one clock after the address
   always @(posedge clock) bus.dado <= rom[bus.endereco];
   // scoreboard: pop one expected cycle per falling edge and compare
   always @(negedge clock) begin
      if (q.size() > 0) begin
         e = q.pop_front();
         sb_cyc++;
         checks++;
         if (bus.leds !== e.leds) $display("FAIL sb_leds entry %0d got %0h want %0h", sb_cyc, bus.leds, e.leds);
         else passed++;
         checks++;
         if (bus.pronto !== e.pronto) $display("FAIL sb_pronto entry %0d got %0b want %0b", sb_cyc, bus.pronto, e.pronto);
         else passed++;
         checks++;
         if (bus.exibindo !== e.exib) $display("FAIL sb_exibindo entry %0d got %0b want %0b", sb_cyc, bus.exibindo, e.exib);
         else passed++;
         checks++;
         if (bus.db_estado !== e.est) $display("FAIL sb_estado entry %0d got %0d want %0d", sb_cyc, bus.db_estado, e.est);
         else passed++;
         if (e.ender_ok) begin
            checks++;
            if (bus.endereco !== e.ender) $display("FAIL sb_endereco entry %0d got %0d want %0d", sb_cyc, bus.endereco, e.ender);
            else passed++;
         end
      end
   end
   task automatic push_run(input int n, input int idle);
      exp_t x;
      for (int c = 1; c <= n * PER + 1 + idle; c++) begin
         int k = (c - 1) / PER;
         int p = (c - 1) % PER;
         if (c > n * PER + 1) x = '{4'd0, 1'b0, 1'b0, 3'd0, 4'd0, 1'b1};
         else if (c == n * PER + 1) x = '{4'd0, 1'b1, 1'b0, 3'd6, 4'd0, 1'b0};
         else begin
            x.est      = p == 0 ? 3'd1 : p == 1 ? 3'd2 : p < 2 + TA ? 3'd3 : p < 2 + TA + TP ? 3'd4 : 3'd5;
            x.leds     = x.est == 3'd3 ? rom[k] : 4'd0;
            x.pronto   = 1'b0;
            x.exib     = 1'b1;
            x.ender    = 4'(k);
            x.ender_ok = 1'b1;
         end
         q.push_back(x);
      end
   endtask
   task automatic start(input logic [3:0] lim);
      #1;
      bus.limite  = lim;
      bus.iniciar = 1'b1;
      @(posedge clock);
      #1 bus.iniciar = 1'b0;
   endtask
   task automatic drain(input int budget);
      for (int i = 0; i < budget && q.size() > 0; i++) @(posedge clock);
   endtask
   task automatic test_reset;
      reset = 1'b0;
      repeat (3) @(posedge clock);
      #1 reset = 1'b1;
      @(negedge clock);
      checks++;
      if (bus.leds !== 4'd0) $display("FAIL reset_leds got %0h want 0", bus.leds); else passed++;
      checks++;
      if (bus.endereco !== 4'd0) $display("FAIL reset_endereco got %0d want 0", bus.endereco); else passed++;
      checks++;
      if (bus.exibindo !== 1'b0) $display("FAIL reset_exibindo got %0b want 0", bus.exibindo); else passed++;
      checks++;
      if (bus.pronto !== 1'b0) $display("FAIL reset_pronto got %0b want 0", bus.pronto); else passed++;
      checks++;
      if (bus.db_estado !== 3'd0) $display("FAIL reset_estado got %0d want 0", bus.db_estado); else passed++;
      @(posedge clock);
   endtask
   task automatic test_sequence(input logic [3:0] lim, input string name);
      start(lim);
      push_run(int'(lim) + 1, 2);
      drain(200);
      checks++;
      if (q.size() != 0) begin
         $display("FAIL %s_timeout left %0d want 0", name, q.size());
         q.delete();
      end else passed++;
   endtask
   task automatic test_ignore_mid;
      start(4'd2);
      push_run(3, 3);
      repeat (5) @(posedge clock);
      #1 bus.limite = 4'd5;
      bus.iniciar = 1'b1;
      @(posedge clock);
      #1 bus.iniciar = 1'b0;
      repeat (9) @(posedge clock);
      #1 bus.iniciar = 1'b1;
      @(posedge clock);
      #1 bus.iniciar = 1'b0;
      drain(100);
      checks++;
      if (q.size() != 0) begin
         $display("FAIL ignore_timeout left %0d want 0", q.size());
         q.delete();
      end else passed++;
      bus.limite = 4'd0;
   endtask
   task automatic test_parar;
      bit seen = 0;
      start(4'd2);
      push_run(3, 0);
      while (q.size() > PER + 2 + 2) void'(q.pop_back());
      repeat (PER + 4) @(negedge clock);
      bus.parar = 1'b1;
      @(posedge clock);
      #1 bus.parar = 1'b0;
      @(negedge clock);
      checks++;
      if (bus.db_estado !== 3'd0) $display("FAIL parar_estado got %0d want 0", bus.db_estado); else passed++;
      checks++;
      if (bus.leds !== 4'd0) $display("FAIL parar_leds got %0h want 0", bus.leds); else passed++;
      checks++;
      if (bus.endereco !== 4'd0) $display("FAIL parar_endereco got %0d want 0", bus.endereco); else passed++;
      for (int i = 0; i < 40; i++) begin
         @(negedge clock);
         if (bus.pronto === 1'b1) seen = 1;
      end
      checks++;
      if (seen) $display("FAIL parar_pronto got 1 want 0"); else passed++;
      checks++;
      if (q.size() != 0) begin
         $display("FAIL parar_queue left %0d want 0", q.size());
         q.delete();
      end else passed++;
      @(posedge clock);
      test_sequence(4'd2, "restart");
   endtask
   task automatic test_reset_mid;
      bit busy = 0;
      start(4'd2);
      push_run(3, 0);
      while (q.size() > 2 + TA + 1) void'(q.pop_back());
      repeat (2 + TA + 1) @(negedge clock);
      #1 reset = 1'b0;
      #1;
      checks++;
      if (bus.db_estado !== 3'd0) $display("FAIL rstmid_estado got %0d want 0", bus.db_estado); else passed++;
      checks++;
      if (bus.exibindo !== 1'b0) $display("FAIL rstmid_exibindo got %0b want 0", bus.exibindo); else passed++;
      checks++;
      if (bus.endereco !== 4'd0) $display("FAIL rstmid_endereco got %0d want 0", bus.endereco); else passed++;
      checks++;
      if (bus.leds !== 4'd0 || bus.pronto !== 1'b0) $display("FAIL rstmid_outputs got %0h/%0b want 0/0", bus.leds, bus.pronto); else passed++;
      checks++;
      if (q.size() != 0) begin
         $display("FAIL rstmid_queue left %0d want 0", q.size());
         q.delete();
      end else passed++;
      repeat (2) @(posedge clock);
      #1 reset = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         if (bus.db_estado !== 3'd0 || bus.exibindo !== 1'b0) busy = 1;
      end
      checks++;
      if (busy) $display("FAIL rstmid_idle got busy want idle"); else passed++;
      @(posedge clock);
   endtask
   initial begin
      bus.iniciar = 1'b0;
      bus.parar   = 1'b0;
      bus.limite  = 4'd0;
      test_reset;
      test_sequence(4'd2, "seq3");
      test_sequence(4'd0, "lim0");
      test_sequence(4'd15, "lim15");
      test_ignore_mid;
      test_parar;
      test_reset_mid;
      test_sequence(4'd1, "after_reset");
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
